// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit holding architectural HI/LO for the EX stage.
// The result is computed at issue, parked in pending registers, and committed when the countdown expires.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] pend_hi, pend_lo, pend_hi_next, pend_lo_next;
  logic [WIDTH-1:0] hi_next, lo_next;

  logic               is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic [WIDTH-1:0]   a_mag, b_mag, divisor, quo_mag, rem_mag, div_q, div_r;

  // Signed ops run on magnitudes and fix the signs afterwards; 0x80000000 / -1 falls out naturally.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mul_a     = {{WIDTH{a_neg}}, a};
    mul_b     = {{WIDTH{b_neg}}, b};
    product   = mul_a * mul_b;
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    divisor   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    quo_mag   = a_mag / divisor;
    rem_mag   = a_mag % divisor;
    div_q     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    div_r     = a_neg ? -rem_mag : rem_mag;
    if (b == '0) begin
      div_q = '1;
      div_r = a;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    hi_next      = hi;
    lo_next      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_next = product[2*WIDTH-1:WIDTH];
              pend_lo_next = product[WIDTH-1:0];
              count_next   = MULT_N;
              state_next   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_next = div_r;
              pend_lo_next = div_q;
              count_next   = DIV_N;
              state_next   = RUN;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts arriving here are dropped; the hazard unit should never send them.
        if (count <= ONE) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count - ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      hi      <= hi_next;
      lo      <= lo_next;
    end
  end

  assign busy = (state == RUN);

endmodule
